// File: rtl/proto_byte_window.sv
// proto_byte_window
//   Buffers a serial byte stream (valid/ready, one byte per cycle) in a
//   DEPTH-entry FIFO and presents the four oldest bytes as a window for the
//   protobuf key decoder. The window never spans a message boundary. Downstream
//   logic retires 1-4 bytes per cycle (consume) or bulk-discards a payload (skip).
//
//   Optional feature: define PROTO_WINDOW_BYTE_COUNT_EN to add io_byte_count,
//   a free-running 32-bit count of all bytes retired by consume or skip.
//
// Ports
//   clock, reset (async, active-low)
//   io_in_valid/io_in_ready/io_in_data/io_in_last : byte input handshake
//   io_input_0..3        : window lanes, _0 oldest, masked lanes read 0
//   io_window_valid/count/last : window status
//   io_consume_valid/count     : retire 1-4 bytes from the head
//   io_skip_valid/len/busy     : discard len bytes
//   io_error             : sticky protocol error
//   io_byte_count        : retired byte counter (PROTO_WINDOW_BYTE_COUNT_EN only)
module proto_byte_window #(
   parameter int DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [7:0]  io_in_data,
   input  logic        io_in_last,
   output logic [7:0]  io_input_0,
   output logic [7:0]  io_input_1,
   output logic [7:0]  io_input_2,
   output logic [7:0]  io_input_3,
   output logic        io_window_valid,
   output logic [2:0]  io_window_count,
   output logic        io_window_last,
   input  logic        io_consume_valid,
   input  logic [2:0]  io_consume_count,
   input  logic        io_skip_valid,
   input  logic [15:0] io_skip_len,
   output logic        io_skip_busy,
   output logic        io_error
`ifdef PROTO_WINDOW_BYTE_COUNT_EN
  ,output logic [31:0] io_byte_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {ST_NORMAL, ST_SKIP} state_t;

   state_t         state_q, state_d;
   logic [8:0]     mem_q [DEPTH];
   logic [8:0]     mem_d [DEPTH];
   logic [AW-1:0]  rptr_q, rptr_d;
   logic [AW-1:0]  wptr_q, wptr_d;
   logic [AW:0]    occ_q, occ_d;
   logic [15:0]    rem_q, rem_d;
   logic           err_q, err_d;

   logic           push;
   logic [2:0]     pop;
   logic [7:0]     win_data [4];
   logic [2:0]     win_cnt;
   logic           win_last;
   logic           win_stop;
   logic [15:0]    skip_lim;
   logic [2:0]     skip_disc;
   logic           skip_overrun;
   logic           skip_stop;
   logic [8:0]     ent;

   // Window: walk the head entries, stop after the first message-final byte
   always_comb begin
      win_cnt  = '0;
      win_last = 1'b0;
      win_stop = 1'b0;
      ent      = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         win_data[i] = '0;
         if (!win_stop && ((AW+1)'(i) < occ_q)) begin
            ent         = mem_q[rptr_q + AW'(i)];
            win_data[i] = ent[7:0];
            win_cnt     = win_cnt + 3'd1;
            if (ent[8]) begin
               win_last = 1'b1;
               win_stop = 1'b1;
            end
         end else begin
            win_stop = 1'b1;
         end
      end
   end

   // Skip discard: d = min(4, occupancy, remaining), truncated at a last byte.
   // A last byte with more still owed is an overrun.
   always_comb begin
      skip_lim = 16'd4;
      if (16'(occ_q) < skip_lim) skip_lim = 16'(occ_q);
      if (rem_q < skip_lim) skip_lim = rem_q;
      skip_disc    = '0;
      skip_overrun = 1'b0;
      skip_stop    = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!skip_stop && (16'(i) < skip_lim)) begin
            skip_disc = skip_disc + 3'd1;
            if (mem_q[rptr_q + AW'(i)][8]) begin
               skip_stop = 1'b1;
               if (rem_q > 16'(i + 1)) skip_overrun = 1'b1;
            end
         end
      end
   end

   assign io_input_0      = win_data[0];
   assign io_input_1      = win_data[1];
   assign io_input_2      = win_data[2];
   assign io_input_3      = win_data[3];
   assign io_window_count = win_cnt;
   assign io_window_last  = win_last;
   assign io_window_valid = (state_q == ST_NORMAL) && ((win_cnt == 3'd4) || win_last);
   assign io_in_ready     = occ_q < (AW+1)'(DEPTH);
   assign io_skip_busy    = (state_q == ST_SKIP);
   assign io_error        = err_q;

   assign push = io_in_valid && io_in_ready;

   // Control: consume is applied before a same-cycle skip is loaded
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      err_d   = err_q;
      pop     = '0;
      unique case (state_q)
         ST_NORMAL: begin
            if (io_consume_valid) begin
               if (io_window_valid && (io_consume_count != 3'd0) &&
                   (io_consume_count <= win_cnt))
                  pop = io_consume_count;
               else
                  err_d = 1'b1;
            end
            if (io_skip_valid && (io_skip_len != '0)) begin
               rem_d   = io_skip_len;
               state_d = ST_SKIP;
            end
         end
         ST_SKIP: begin
            if (io_consume_valid || io_skip_valid) err_d = 1'b1;
            pop = skip_disc;
            if (skip_overrun) begin
               err_d   = 1'b1;
               rem_d   = '0;
               state_d = ST_NORMAL;
            end else begin
               rem_d = rem_q - 16'(skip_disc);
               if (rem_d == '0) state_d = ST_NORMAL;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wptr_q] = {io_in_last, io_in_data};
      wptr_d = wptr_q + AW'(push);
      rptr_d = rptr_q + AW'(pop);
      occ_d  = occ_q + (AW+1)'(push) - (AW+1)'(pop);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_NORMAL;
         mem_q   <= '{default: '0};
         rptr_q  <= '0;
         wptr_q  <= '0;
         occ_q   <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         occ_q   <= occ_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

`ifdef PROTO_WINDOW_BYTE_COUNT_EN
   logic [31:0] byte_cnt_q, byte_cnt_d;

   always_comb byte_cnt_d = byte_cnt_q + 32'(pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) byte_cnt_q <= '0;
      else        byte_cnt_q <= byte_cnt_d;
   end

   assign io_byte_count = byte_cnt_q;
`endif

endmodule
